// File: rtl/msu_pkg.sv
// Shared definitions for the MSU data stream reader: FSM state codes,
// default prefetch depth and a small address helper.
package msu_pkg;

    localparam int MSU_FIFO_DEPTH = 8;

    typedef logic [1:0] msu_state_t;

    localparam msu_state_t ST_IDLE  = 2'd0;
    localparam msu_state_t ST_RUN   = 2'd1;
    localparam msu_state_t ST_REQ   = 2'd2;
    localparam msu_state_t ST_DRAIN = 2'd3;

    // HPS fetches whole 16-bit words, so requests always use the even address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/msu_data_reader_if.sv
// Word-fetch bus between the MSU data reader and the HPS side.
interface msu_data_reader_if;

    logic        hps_req;
    logic [31:0] hps_addr;
    logic        hps_ack;
    logic [15:0] hps_data;

    modport master (
        output hps_req,
        output hps_addr,
        input  hps_ack,
        input  hps_data
    );

    modport slave (
        input  hps_req,
        input  hps_addr,
        output hps_ack,
        output hps_data
    );

endinterface

// File: rtl/msu_byte_fifo.sv
// Byte prefetch buffer: accepts up to two bytes per cycle (b0 first),
// releases one byte per cycle, and can be flushed in a single cycle.
module msu_byte_fifo
    import msu_pkg::*;
#(
    parameter int DEPTH = MSU_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          flush,
    input  logic [1:0]    push_cnt,
    input  logic [7:0]    push_b0,
    input  logic [7:0]    push_b1,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_next;
    logic          pop_ok;

    assign wr_ptr_next = wr_ptr + AW'(1);
    assign pop_ok      = pop && (count != '0);
    assign head        = mem[rd_ptr];

    // Byte storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge CLK) begin
        if (!flush) begin
            if (push_cnt != 2'd0) mem[wr_ptr]      <= push_b0;
            if (push_cnt == 2'd2) mem[wr_ptr_next] <= push_b1;
        end
    end

    // Pointers and occupancy; flush empties the buffer regardless of push/pop.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_cnt);
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_cnt) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/msu_data_reader.sv
// MSU-1 data port reader: prefetches the byte stream from HPS memory one
// 16-bit word at a time and presents it to the SNES $2001 register.
module msu_data_reader
    import msu_pkg::*;
#(
    parameter int FIFO_DEPTH = MSU_FIFO_DEPTH,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              seek,
    input  logic [31:0]       seek_addr,
    input  logic              advance,
    output logic [7:0]        data_out,
    output logic              data_busy,
    msu_data_reader_if.master hps
);

    msu_state_t    state;
    logic [31:0]   fetch_addr;
    logic [31:0]   req_addr;
    logic          skip_low;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic [1:0]    push_cnt;
    logic          in_req;
    logic          ack_take;
    logic          pop_req;
    logic          room_ok;

    // A request is outstanding in REQ and while draining a superseded one.
    assign in_req   = (state == ST_REQ) || (state == ST_DRAIN);
    // Only an ack for the live request is kept; a same-cycle seek discards it.
    assign ack_take = hps.hps_ack && (state == ST_REQ) && !seek;
    assign pop_req  = advance && !busy && !seek;
    // Room for a full word, judged on the current count only.
    assign room_ok  = fifo_count <= CW'(FIFO_DEPTH - 2);
    assign push_cnt = !ack_take ? 2'd0 : (skip_low ? 2'd1 : 2'd2);

    assign hps.hps_req  = in_req;
    assign hps.hps_addr = req_addr;
    assign data_out     = (fifo_count != '0) ? fifo_head : 8'h00;
    assign data_busy    = busy;

    msu_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .flush    (seek),
        .push_cnt (push_cnt),
        .push_b0  (skip_low ? hps.hps_data[15:8] : hps.hps_data[7:0]),
        .push_b1  (hps.hps_data[15:8]),
        .pop      (pop_req),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    // Fetch sequencing: seek restarts the stream, acks advance the fetch pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            fetch_addr <= '0;
            req_addr   <= '0;
            skip_low   <= 1'b0;
        end else if (seek) begin
            fetch_addr <= word_align(seek_addr);
            skip_low   <= seek_addr[0];
            if (in_req && !hps.hps_ack) begin
                // Old request still in flight: keep the bus stable until it acks.
                state <= ST_DRAIN;
            end else begin
                state    <= ST_REQ;
                req_addr <= word_align(seek_addr);
            end
        end else begin
            case (state)
                ST_RUN: begin
                    if (room_ok) begin
                        state    <= ST_REQ;
                        req_addr <= fetch_addr;
                    end
                end
                ST_REQ: begin
                    if (hps.hps_ack) begin
                        state      <= ST_RUN;
                        skip_low   <= 1'b0;
                        fetch_addr <= fetch_addr + 32'd2;
                    end
                end
                ST_DRAIN: begin
                    if (hps.hps_ack) begin
                        state    <= ST_REQ;
                        req_addr <= fetch_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Busy from seek until at least two bytes have been buffered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy <= 1'b0;
        end else if (seek) begin
            busy <= 1'b1;
        end else if (busy && (fifo_count >= CW'(2))) begin
            busy <= 1'b0;
        end
    end

endmodule
